// File: rtl/pstx_if.sv
// PS/2 host-transmitter bus: user request/status handshake plus open-drain line controls.
interface pstx_if;
    logic [7:0] DATA_IN;
    logic       START;
    logic       BUSY;
    logic       DONE;
    logic       Tx_error;
    logic       PS2_CLK_I;
    logic       PS2_CLK_OE;
    logic       PS2_DATA_I;
    logic       PS2_DATA_OE;

    modport slave (
        input  DATA_IN, START, PS2_CLK_I, PS2_DATA_I,
        output BUSY, DONE, Tx_error, PS2_CLK_OE, PS2_DATA_OE
    );

    modport master (
        output DATA_IN, START, PS2_CLK_I, PS2_DATA_I,
        input  BUSY, DONE, Tx_error, PS2_CLK_OE, PS2_DATA_OE
    );
endinterface

// File: rtl/pstx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data + odd parity + stop,
// then device ACK sampling, with a no-clock timeout.
module pstx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic   CLKOUT,
    input logic   RST_N,
    pstx_if.slave bus
);
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [3:0]       edge_q, edge_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall_c;

    // Line synchronizers; clk_prev_q holds the prior synced clock for edge detection
    always_ff @(posedge CLKOUT or negedge RST_N) begin
        if (!RST_N) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= bus.PS2_CLK_I;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= bus.PS2_DATA_I;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall_c = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge CLKOUT or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            edge_q    <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            edge_q    <= edge_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Outputs are computed alongside the next state so they are registered with it
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        edge_d    = edge_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (bus.START) begin
                    shreg_d  = {~^bus.DATA_IN, bus.DATA_IN};
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    edge_d   = '0;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REQ: begin
                cnt_d     = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
                state_d   = S_BITS;
            end
            S_BITS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall_c) begin
                    edge_d    = edge_q + 4'd1;
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b1, shreg_q[8:1]};
                    // Tenth edge presents the stop bit, i.e. releases the data line
                    if (edge_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall_c) begin
                    err_d   = dat_s2_q;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Device stopped clocking: abandon the frame and report failure
        if ((state_q == S_BITS || state_q == S_ACK) && cnt_q == TO_LAST) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            err_d     = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
        end
    end

    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.Tx_error    = err_q;
    assign bus.PS2_CLK_OE  = clk_oe_q;
    assign bus.PS2_DATA_OE = data_oe_q;
endmodule

// File: tb/tb_pstx.sv
// Bench for pstx: PS/2 device model on open-drain lines, checked against a frame reference.
module tb_pstx;
    localparam int unsigned H = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pstx_if bus ();
    pstx_if tbus ();

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    assign bus.PS2_CLK_I   = ~(bus.PS2_CLK_OE | dev_clk_low);
    assign bus.PS2_DATA_I  = ~(bus.PS2_DATA_OE | dev_data_low);
    assign tbus.PS2_CLK_I  = ~tbus.PS2_CLK_OE;
    assign tbus.PS2_DATA_I = ~tbus.PS2_DATA_OE;

    pstx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(1000)) dut (
        .CLKOUT(clk), .RST_N(rst_n), .bus(bus)
    );
    pstx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(100)) dut_to (
        .CLKOUT(clk), .RST_N(rst_n), .bus(tbus)
    );

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    logic last_err = 1'b0;

    always @(negedge clk) begin
        if (bus.DONE) begin
            done_cnt++;
            last_err = bus.Tx_error;
        end
    end

    // Line sequence seen by the device: start, 8 data LSB first, odd parity, stop
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ($countones(b) % 2 == 0);
        f[10]  = 1'b1;
        return f;
    endfunction

    // Device: mode 0 ACKs, mode 1 leaves data high; abort_edge>0 asserts reset during that edge
    task automatic device(input int mode, input int abort_edge, output logic [10:0] bits, output bit seen);
        seen = 1'b0;
        bits = '0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.PS2_CLK_I && !bus.PS2_DATA_I) seen = 1'b1;
        end
        if (!seen) return;
        bits[0] = bus.PS2_DATA_I;
        for (int e = 1; e <= 10; e++) begin
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            if (e == abort_edge) begin
                repeat (4) @(negedge clk);
                #1 rst_n = 1'b0;
                return;
            end
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            bits[e] = bus.PS2_DATA_I;
        end
        repeat (H) @(negedge clk);
        if (mode == 0) dev_data_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit got);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done_cnt != d0) got = 1'b1;
        end
    endtask

    task automatic do_frame(input logic [7:0] b, input int mode, output logic [10:0] bits,
                            output bit seen, output logic busy_seen, output bit got, output logic err);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        bus.DATA_IN = b;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START   = 1'b0;
        busy_seen   = bus.BUSY;
        bus.DATA_IN = 8'($urandom);
        device(mode, 0, bits, seen);
        wait_done(d0, got);
        err = last_err;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total += 5;
        if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        if (bus.DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
        if (bus.Tx_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.Tx_error); end
        if (bus.PS2_CLK_OE !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b exp=0", bus.PS2_CLK_OE); end
        if (bus.PS2_DATA_OE !== 1'b0) begin bad++; $display("FAIL reset_data_oe got=%b exp=0", bus.PS2_DATA_OE); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frames();
        logic [7:0]  bytes[$];
        logic [10:0] bits;
        bit          seen, got;
        logic        busy_seen, err;
        int          d0;
        bytes = '{8'hED, 8'h07, 8'hFF};
        for (int i = 0; i < 5; i++) bytes.push_back(8'($urandom));
        foreach (bytes[i]) begin
            d0 = done_cnt;
            do_frame(bytes[i], 0, bits, seen, busy_seen, got, err);
            total += 6;
            if (busy_seen !== 1'b1) begin bad++; $display("FAIL frame_busy byte=%h got=%b exp=1", bytes[i], busy_seen); end
            if (!seen) begin bad++; $display("FAIL frame_rts byte=%h got=none exp=request", bytes[i]); end
            if (bits !== ref_frame(bytes[i])) begin bad++; $display("FAIL frame_bits byte=%h got=%b exp=%b", bytes[i], bits, ref_frame(bytes[i])); end
            if (!got || done_cnt - d0 != 1) begin bad++; $display("FAIL frame_done byte=%h got=%0d exp=1", bytes[i], done_cnt - d0); end
            if (err !== 1'b0) begin bad++; $display("FAIL frame_err byte=%h got=%b exp=0", bytes[i], err); end
            if (bus.PS2_CLK_OE !== 1'b0 || bus.PS2_DATA_OE !== 1'b0 || bus.BUSY !== 1'b0) begin
                bad++; $display("FAIL frame_release byte=%h got=%b%b%b exp=000", bytes[i], bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY);
            end
        end
    endtask

    task automatic test_nack();
        logic [10:0] bits;
        bit          seen, got;
        logic        busy_seen, err;
        logic [7:0]  b;
        b = 8'($urandom);
        do_frame(b, 1, bits, seen, busy_seen, got, err);
        total += 4;
        if (bits !== ref_frame(b)) begin bad++; $display("FAIL nack_bits got=%b exp=%b", bits, ref_frame(b)); end
        if (!got) begin bad++; $display("FAIL nack_done got=0 exp=1"); end
        if (err !== 1'b1) begin bad++; $display("FAIL nack_err got=%b exp=1", err); end
        if (bus.PS2_CLK_OE !== 1'b0 || bus.PS2_DATA_OE !== 1'b0) begin
            bad++; $display("FAIL nack_release got=%b%b exp=00", bus.PS2_CLK_OE, bus.PS2_DATA_OE);
        end
    endtask

    task automatic test_timeout();
        int n_inh, n_req, n_bits;
        @(negedge clk);
        tbus.DATA_IN = 8'($urandom);
        tbus.START   = 1'b1;
        @(negedge clk);
        tbus.START   = 1'b0;
        n_inh = 0;
        while (tbus.PS2_CLK_OE && !tbus.PS2_DATA_OE && n_inh < 1000) begin n_inh++; @(negedge clk); end
        n_req = 0;
        while (tbus.PS2_CLK_OE && tbus.PS2_DATA_OE && n_req < 1000) begin n_req++; @(negedge clk); end
        n_bits = 0;
        while (!tbus.DONE && n_bits < 1000) begin n_bits++; @(negedge clk); end
        total += 5;
        if (n_inh != 10) begin bad++; $display("FAIL inhibit_len got=%0d exp=10", n_inh); end
        if (n_req != 1) begin bad++; $display("FAIL req_len got=%0d exp=1", n_req); end
        if (n_bits != 100) begin bad++; $display("FAIL timeout_len got=%0d exp=100", n_bits); end
        if (tbus.Tx_error !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", tbus.Tx_error); end
        if (tbus.PS2_CLK_OE !== 1'b0 || tbus.PS2_DATA_OE !== 1'b0 || tbus.BUSY !== 1'b0) begin
            bad++; $display("FAIL timeout_release got=%b%b%b exp=000", tbus.PS2_CLK_OE, tbus.PS2_DATA_OE, tbus.BUSY);
        end
        @(negedge clk);
        total += 1;
        if (tbus.DONE !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%b exp=0", tbus.DONE); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        bit          seen, got;
        logic        busy_seen, err;
        int          d0;
        d0 = done_cnt;
        @(negedge clk);
        bus.DATA_IN = 8'($urandom);
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START   = 1'b0;
        device(0, 5, bits, seen);
        #1;
        total += 2;
        if (!seen) begin bad++; $display("FAIL abort_rts got=none exp=request"); end
        if (bus.PS2_CLK_OE !== 1'b0 || bus.PS2_DATA_OE !== 1'b0 || bus.BUSY !== 1'b0) begin
            bad++; $display("FAIL abort_release got=%b%b%b exp=000", bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY);
        end
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total += 1;
        if (done_cnt != d0) begin bad++; $display("FAIL abort_done got=%0d exp=0", done_cnt - d0); end
        do_frame(8'hAA, 0, bits, seen, busy_seen, got, err);
        total += 3;
        if (bits !== ref_frame(8'hAA)) begin bad++; $display("FAIL after_abort_bits got=%b exp=%b", bits, ref_frame(8'hAA)); end
        if (!got) begin bad++; $display("FAIL after_abort_done got=0 exp=1"); end
        if (err !== 1'b0) begin bad++; $display("FAIL after_abort_err got=%b exp=0", err); end
    endtask

    task automatic test_ignore();
        logic [10:0] bits;
        bit          seen, got;
        logic [7:0]  b1;
        int          d0;
        b1 = 8'($urandom);
        d0 = done_cnt;
        @(negedge clk);
        bus.DATA_IN = b1;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.START   = 1'b0;
        fork
            device(0, 0, bits, seen);
            begin
                repeat (3) @(negedge clk);
                bus.DATA_IN = ~b1;
                bus.START   = 1'b1;
                @(negedge clk);
                bus.START   = 1'b0;
                repeat (40) @(negedge clk);
                bus.DATA_IN = b1 ^ 8'h5A;
                bus.START   = 1'b1;
                @(negedge clk);
                bus.START   = 1'b0;
            end
        join
        wait_done(d0, got);
        repeat (100) @(negedge clk);
        total += 3;
        if (bits !== ref_frame(b1)) begin bad++; $display("FAIL ignore_bits got=%b exp=%b", bits, ref_frame(b1)); end
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt - d0); end
        if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%b exp=0", bus.BUSY); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits1, bits2;
        bit          seen, got;
        logic [7:0]  b1, b2;
        int          n, d0;
        b1 = 8'($urandom);
        b2 = ~b1;
        @(negedge clk);
        bus.DATA_IN = b1;
        bus.START   = 1'b1;
        @(negedge clk);
        bus.DATA_IN = b2;
        device(0, 0, bits1, seen);
        n = 0;
        while (!bus.DONE && n < 100) begin n++; @(negedge clk); end
        @(negedge clk);
        total += 3;
        if (bits1 !== ref_frame(b1)) begin bad++; $display("FAIL b2b_first_bits got=%b exp=%b", bits1, ref_frame(b1)); end
        if (n >= 100) begin bad++; $display("FAIL b2b_first_done got=none exp=pulse"); end
        if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b exp=1", bus.BUSY); end
        bus.START = 1'b0;
        d0 = done_cnt;
        device(0, 0, bits2, seen);
        wait_done(d0, got);
        total += 3;
        if (bits2 !== ref_frame(b2)) begin bad++; $display("FAIL b2b_second_bits got=%b exp=%b", bits2, ref_frame(b2)); end
        if (!got) begin bad++; $display("FAIL b2b_second_done got=0 exp=1"); end
        if (last_err !== 1'b0) begin bad++; $display("FAIL b2b_second_err got=%b exp=0", last_err); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.START    = 1'b0;
        bus.DATA_IN  = 8'h00;
        tbus.START   = 1'b0;
        tbus.DATA_IN = 8'h00;
        test_reset();
        test_frames();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pstx.md
PSTX -- requirements
Module: pstx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: CLKOUT cycles the PS/2 clock is held low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: CLKOUT cycles allowed from clock release to ACK sample (20 ms at 50 MHz).
REQ-003 SHALL have port CLKOUT  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port DATA_IN  input  8  byte to send to the device.
REQ-006 SHALL have port START  input  1  request to send DATA_IN; sampled only when BUSY=0.
REQ-007 SHALL have port BUSY  output  1  high from the cycle after START acceptance until return to IDLE.
REQ-008 SHALL have port DONE  output  1  one-cycle pulse at end of every transfer, successful or failed.
REQ-009 SHALL have port Tx_error  output  1  valid with DONE; 1 = NACK or timeout; holds until next START acceptance.
REQ-010 SHALL have port PS2_CLK_I  input  1  PS/2 clock line level.
REQ-011 SHALL have port PS2_CLK_OE  output  1  1 = drive PS/2 clock low; 0 = release.
REQ-012 SHALL have port PS2_DATA_I  input  1  PS/2 data line level.
REQ-013 SHALL have port PS2_DATA_OE  output  1  1 = drive PS/2 data low; 0 = release.

Function
REQ-014 SHALL pass PS2_CLK_I and PS2_DATA_I through 2-flop synchronizers; a falling edge is previous synced clock 1, current 0.
REQ-015 SHALL implement states IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE.
REQ-016 In IDLE with START=1: SHALL latch DATA_IN, compute odd parity (parity = ~^DATA_IN), clear Tx_error, and enter INHIBIT next cycle.
REQ-017 INHIBIT: PS2_CLK_OE=1, PS2_DATA_OE=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-018 REQ: one cycle with PS2_CLK_OE=1 and PS2_DATA_OE=1 (start bit 0), then BITS.
REQ-019 BITS: PS2_CLK_OE=0; PS2_DATA_OE=1 (start bit) until first falling edge; timeout counter cleared on entry.
REQ-020 On falling edges 1-8 SHALL present data bits 0-7 LSB first, on edge 9 the parity bit, on edge 10 the stop bit; PS2_DATA_OE = inverse of presented bit, updated the cycle after edge detection.
REQ-021 On edge 10 SHALL release data (PS2_DATA_OE=0) and enter ACK.
REQ-022 ACK: on next falling edge SHALL sample synced data; 0 = ACK (Tx_error=0), 1 = NACK (Tx_error=1); then WAIT_IDLE.
REQ-023 WAIT_IDLE: wait until synced clock and data both 1, then pulse DONE one cycle and return to IDLE.
REQ-024 If the timeout counter reaches TIMEOUT_CYCLES in BITS or ACK: SHALL release both lines, set Tx_error=1, pulse DONE, enter IDLE.
REQ-025 START while BUSY=1 SHALL be ignored; DATA_IN changes after acceptance SHALL not affect the frame.
REQ-026 START held high through DONE SHALL begin a new transfer the cycle after IDLE is re-entered.
REQ-027 Counters SHALL be wide enough for their parameter and never wrap within a transfer.

Reset
REQ-028 RST_N=0 SHALL immediately force IDLE, PS2_CLK_OE=0, PS2_DATA_OE=0, BUSY=0, DONE=0, Tx_error=0, clear counters, bit index and synchronizers (to 1).
REQ-029 Reset asserted mid-transfer SHALL abort silently (no DONE pulse); first START after release SHALL run a full frame.

Verification
REQ-030 START with DATA_IN=0xED, device model ACKs -> data line after start bit: 1,0,1,1,0,1,1,1, parity 1, stop 1; DONE pulse, Tx_error=0.
REQ-031 DATA_IN=0x07 -> parity bit 0; DATA_IN=0xFF -> parity bit 1; both complete with Tx_error=0.
REQ-032 Device holds data high at ACK clock -> DONE pulse with Tx_error=1, both OE 0 afterwards.
REQ-033 Device never clocks after REQ (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=100) -> DONE exactly 100 cycles after BITS entry, Tx_error=1, lines released.
REQ-034 RST_N low during edge 5 of BITS -> both OE 0 same cycle, no DONE; next START with 0xAA completes normally.
REQ-035 START pulsed while BUSY=1 with different DATA_IN -> ignored; only the first byte is transmitted, one DONE pulse.
